// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART RX frame checker.
//   - state_e        : frame sequencer states
//   - DATA_WIDTH_MIN / DATA_WIDTH_MAX : legal data-bit range
//   - STOP_BITS_MIN / STOP_BITS_MAX   : legal stop-bit range
package uart_rx_pkg;

   localparam int unsigned DATA_WIDTH_MIN = 5;
   localparam int unsigned DATA_WIDTH_MAX = 9;
   localparam int unsigned STOP_BITS_MIN  = 1;
   localparam int unsigned STOP_BITS_MAX  = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

endpackage

// File: rtl/uart_rx_parity_acc.sv
// uart_rx_parity_acc: running XOR of received data bits with a parity compare.
// Only instantiated when UART_RX_PARITY_EN is defined.
// Ports:
//   CLK, RST        : clock, asynchronous active-low reset
//   i_clr           : clear the accumulator (start of frame)
//   i_en            : fold i_bit into the accumulator
//   i_bit           : current sampled bit
//   i_parity_type   : 0 = even, 1 = odd
//   o_error         : accumulator ^ i_bit ^ i_parity_type (valid on the parity bit)
module uart_rx_parity_acc (
   input  logic CLK,
   input  logic RST,
   input  logic i_clr,
   input  logic i_en,
   input  logic i_bit,
   input  logic i_parity_type,
   output logic o_error
);

   logic r_acc;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_acc <= 1'b0;
      end else if (i_clr) begin
         r_acc <= 1'b0;
      end else if (i_en) begin
         r_acc <= r_acc ^ i_bit;
      end
   end

   assign o_error = r_acc ^ i_bit ^ i_parity_type;

endmodule

// File: rtl/uart_rx_frame_check.sv
// uart_rx_frame_check: UART receive frame sequencer. Validates the start bit,
// collects DATA_WIDTH bits LSB-first, optionally checks parity, checks
// STOP_BITS stop bits and delivers the word with per-frame error flags.
// Optional feature macro: UART_RX_PARITY_EN (adds Parity_Type port and PARITY state).
// Ports:
//   CLK, RST      : clock, asynchronous active-low reset
//   Frame_Start   : start pulse from falling-edge detector (honoured only when idle)
//   Bit_Valid     : strobe qualifying Sampled_Bit
//   Sampled_Bit   : majority-voted line value
//   Parity_Type   : 0 = even, 1 = odd (UART_RX_PARITY_EN only)
//   Data_Out      : received word, held until the next Data_Valid
//   Data_Valid    : one-cycle pulse on frame completion
//   Start_Glitch  : one-cycle pulse when the start bit samples 1
//   Parity_Error  : parity flag, updated with Data_Valid
//   Stop_Error    : stop flag, updated with Data_Valid
//   Busy          : high whenever the sequencer is not idle
module uart_rx_frame_check
   import uart_rx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  Frame_Start,
   input  logic                  Bit_Valid,
   input  logic                  Sampled_Bit,
`ifdef UART_RX_PARITY_EN
   input  logic                  Parity_Type,
`endif
   output logic [DATA_WIDTH-1:0] Data_Out,
   output logic                  Data_Valid,
   output logic                  Start_Glitch,
   output logic                  Parity_Error,
   output logic                  Stop_Error,
   output logic                  Busy
);

   localparam int unsigned      CNT_W     = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
   localparam logic             LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_data_width
      $error("uart_rx_frame_check: DATA_WIDTH out of range 5..9");
   end
   if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
      $error("uart_rx_frame_check: STOP_BITS must be 1 or 2");
   end

   state_e                r_state;
   state_e                w_state_nxt;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic                  r_stop_cnt;
   logic                  r_stop_err;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_data_valid;
   logic                  r_start_glitch;
   logic                  r_stop_error;

   logic w_start_ok;
   logic w_glitch;
   logic w_data_bit;
   logic w_stop_bit;
   logic w_frame_done;
`ifdef UART_RX_PARITY_EN
   logic w_par_bit;
   logic w_par_cmp;
   logic r_par_err;
   logic r_parity_error;
`endif

   // Next-state decode; each w_* strobe marks which bit the current Bit_Valid is.
   always_comb begin
      w_state_nxt  = r_state;
      w_start_ok   = 1'b0;
      w_glitch     = 1'b0;
      w_data_bit   = 1'b0;
      w_stop_bit   = 1'b0;
      w_frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bit    = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            // A coincident Bit_Valid is not taken as the start bit.
            if (Frame_Start) w_state_nxt = ST_START;
         end
         ST_START: begin
            if (Bit_Valid) begin
               if (Sampled_Bit) begin
                  w_glitch    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_start_ok  = 1'b1;
                  w_state_nxt = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (Bit_Valid) begin
               w_data_bit = 1'b1;
               if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (Bit_Valid) begin
               w_par_bit   = 1'b1;
               w_state_nxt = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (Bit_Valid) begin
               w_stop_bit = 1'b1;
               if (r_stop_cnt == LAST_STOP) begin
                  w_frame_done = 1'b1;
                  w_state_nxt  = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Frame datapath: counters, shift register and sticky stop-error latch.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_stop_err <= 1'b0;
         r_shift    <= '0;
      end else begin
         if (w_start_ok) begin
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_stop_err <= 1'b0;
         end
         if (w_data_bit) begin
            // LSB-first line order: first bit received ends at bit 0.
            r_shift   <= {Sampled_Bit, r_shift[DATA_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (w_stop_bit) begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
            if (!Sampled_Bit) r_stop_err <= 1'b1;
         end
      end
   end

   // Registered outputs; error flags only move when a frame is delivered.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_data_out     <= '0;
         r_data_valid   <= 1'b0;
         r_start_glitch <= 1'b0;
         r_stop_error   <= 1'b0;
      end else begin
         r_data_valid   <= w_frame_done;
         r_start_glitch <= w_glitch;
         if (w_frame_done) begin
            r_data_out   <= r_shift;
            // The final stop bit is still on Sampled_Bit this cycle.
            r_stop_error <= r_stop_err | ~Sampled_Bit;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   uart_rx_parity_acc u_parity_acc (
      .CLK           (CLK),
      .RST           (RST),
      .i_clr         (w_start_ok),
      .i_en          (w_data_bit),
      .i_bit         (Sampled_Bit),
      .i_parity_type (Parity_Type),
      .o_error       (w_par_cmp)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_par_err      <= 1'b0;
         r_parity_error <= 1'b0;
      end else begin
         if (w_start_ok) r_par_err <= 1'b0;
         else if (w_par_bit) r_par_err <= w_par_cmp;
         if (w_frame_done) r_parity_error <= r_par_err;
      end
   end

   assign Parity_Error = r_parity_error;
`else
   assign Parity_Error = 1'b0;
`endif

   assign Data_Out     = r_data_out;
   assign Data_Valid   = r_data_valid;
   assign Start_Glitch = r_start_glitch;
   assign Stop_Error   = r_stop_error;
   assign Busy         = (r_state != ST_IDLE);

endmodule
